// File: rtl/sw_in_edge_ctrl_pkg.sv
// Shared definitions for the switch-input edge controller: register map,
// debounce FSM states and edge-select encodings.
package sw_in_pkg;

    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_IRQMASK  = 2'd1;
    localparam logic [1:0] REG_EDGE_SEL = 2'd2;
    localparam logic [1:0] REG_EDGECAP  = 2'd3;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

    localparam logic [1:0] EDGE_RISE     = 2'd0;
    localparam logic [1:0] EDGE_FALL     = 2'd1;
    localparam logic [1:0] EDGE_BOTH     = 2'd2;
    localparam logic [1:0] EDGE_BOTH_ALT = 2'd3;

    // The debounced level is already the new level when the pulse fires,
    // so a high level means the accepted transition was a rising one.
    function automatic logic edge_match(input logic [1:0] sel, input logic level);
        case (sel)
            EDGE_RISE: return level;
            EDGE_FALL: return ~level;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sw_in_edge_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch-input controller.
interface sw_in_edge_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/sw_in_edge_ctrl_debounce.sv
// One switch line: two-flop synchroniser followed by an IDLE/COUNT debounce
// FSM that emits the accepted level and a one-cycle pulse on each acceptance.
module sw_debounce
    import sw_in_pkg::*;
#(
    parameter int  DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb,
    output logic pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES <= 1);

    logic             sync_0_reg;
    logic             sync_1_reg;
    logic             deb_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] cnt_reg;
    db_state_t        state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0_reg <= 1'b0;
            sync_1_reg <= 1'b0;
            deb_reg    <= 1'b0;
            pulse_reg  <= 1'b0;
            cnt_reg    <= '0;
            state_reg  <= DB_IDLE;
        end else begin
            sync_0_reg <= raw;
            sync_1_reg <= sync_0_reg;
            pulse_reg  <= 1'b0;
            case (state_reg)
                DB_IDLE: begin
                    if (sync_1_reg != deb_reg) begin
                        // With a one-cycle window there is nothing to count.
                        if (SINGLE) begin
                            deb_reg   <= sync_1_reg;
                            pulse_reg <= 1'b1;
                        end else begin
                            state_reg <= DB_COUNT;
                            cnt_reg   <= CNT_W'(1);
                        end
                    end
                end
                DB_COUNT: begin
                    if (sync_1_reg == deb_reg) begin
                        state_reg <= DB_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        deb_reg   <= sync_1_reg;
                        pulse_reg <= 1'b1;
                        state_reg <= DB_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= DB_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign deb   = deb_reg;
    assign pulse = pulse_reg;

endmodule

// File: rtl/sw_in_edge_ctrl.sv
// Interrupt-capable switch input port: per-bit debounce, sticky edge capture
// with W1C, maskable level irq, and an Avalon-MM register interface.
module sw_in_edge_ctrl
    import sw_in_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    sw_in_edge_ctrl_if.slave     bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] deb_vec;
    logic [WIDTH-1:0] pulse_vec;
    logic [WIDTH-1:0] edge_hit;

    logic [WIDTH-1:0] irq_mask_reg;
    logic [1:0]       edge_sel_reg;
    logic [WIDTH-1:0] edge_cap_reg;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] clr_mask;
    logic [31:0]      readdata_reg;
    logic [31:0]      read_mux;
    logic             irq_reg;
    logic             wr_en;
    logic             rd_en;
    logic             unused_wdata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
            sw_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .raw   (in_port[gi]),
                .deb   (deb_vec[gi]),
                .pulse (pulse_vec[gi])
            );
            assign edge_hit[gi] = pulse_vec[gi] & edge_match(edge_sel_reg, deb_vec[gi]);
        end
    endgenerate

    assign wr_en        = bus.chipselect & bus.write;
    assign rd_en        = bus.chipselect & bus.read;
    assign unused_wdata = ^bus.writedata[31:WIDTH];

    // A fresh edge on the same cycle as its W1C leaves the bit set.
    always_comb begin
        clr_mask = '0;
        if (wr_en && bus.address == REG_EDGECAP) begin
            clr_mask = bus.writedata[WIDTH-1:0];
        end
        edge_cap_next = (edge_cap_reg & ~clr_mask) | edge_hit;
    end

    always_comb begin
        read_mux = '0;
        case (bus.address)
            REG_DATA:     read_mux = 32'(deb_vec);
            REG_IRQMASK:  read_mux = 32'(irq_mask_reg);
            REG_EDGE_SEL: read_mux = 32'(edge_sel_reg);
            REG_EDGECAP:  read_mux = 32'(edge_cap_reg);
            default:      read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_reg <= '0;
            edge_sel_reg <= '0;
            edge_cap_reg <= '0;
            readdata_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_en && bus.address == REG_IRQMASK) begin
                irq_mask_reg <= bus.writedata[WIDTH-1:0];
            end
            if (wr_en && bus.address == REG_EDGE_SEL) begin
                edge_sel_reg <= bus.writedata[1:0];
            end
            edge_cap_reg <= edge_cap_next;
            irq_reg      <= |(edge_cap_reg & irq_mask_reg);
            if (rd_en) begin
                readdata_reg <= read_mux;
            end
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq          = irq_reg;

endmodule
